// File: rtl/dual_issue_scheduler_if.sv
// Decode/issue bundle for the dual-issue scheduler.
// Decode drives the instruction pair; the scheduler drives steering.
interface dual_issue_scheduler_if #(
    parameter int STALL_CNT_W = 32
);
    logic                   dec_valid_0;
    logic                   dec_valid_1;
    logic                   dec_is_mem_0;
    logic                   dec_is_mem_1;
    logic                   dec_is_load_0;
    logic                   dec_is_load_1;
    logic                   dec_is_ctrl_0;
    logic                   dec_is_ctrl_1;
    logic [4:0]             dec_rs1_0;
    logic [4:0]             dec_rs1_1;
    logic [4:0]             dec_rs2_0;
    logic [4:0]             dec_rs2_1;
    logic [4:0]             dec_rd_0;
    logic [4:0]             dec_rd_1;
    logic                   dec_rf_we_0;
    logic                   dec_rf_we_1;
    logic                   flush;
    logic                   dec_ready;
    logic                   iss_valid_br;
    logic                   iss_valid_mem;
    logic                   iss_src_br;
    logic                   iss_src_mem;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output dec_valid_0, dec_valid_1,
        output dec_is_mem_0, dec_is_mem_1,
        output dec_is_load_0, dec_is_load_1,
        output dec_is_ctrl_0, dec_is_ctrl_1,
        output dec_rs1_0, dec_rs1_1,
        output dec_rs2_0, dec_rs2_1,
        output dec_rd_0, dec_rd_1,
        output dec_rf_we_0, dec_rf_we_1,
        output flush,
        input  dec_ready,
        input  iss_valid_br, iss_valid_mem,
        input  iss_src_br, iss_src_mem,
        input  stall_cnt
    );

    modport slave (
        input  dec_valid_0, dec_valid_1,
        input  dec_is_mem_0, dec_is_mem_1,
        input  dec_is_load_0, dec_is_load_1,
        input  dec_is_ctrl_0, dec_is_ctrl_1,
        input  dec_rs1_0, dec_rs1_1,
        input  dec_rs2_0, dec_rs2_1,
        input  dec_rd_0, dec_rd_1,
        input  dec_rf_we_0, dec_rf_we_1,
        input  flush,
        output dec_ready,
        output iss_valid_br, iss_valid_mem,
        output iss_src_br, iss_src_mem,
        output stall_cnt
    );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Issue-stage controller: picks slots, steers them to Branch/Memory pipes,
// tracks load-use hazards and back-pressures decode.
module dual_issue_scheduler #(
    parameter int LOAD_LAT    = 2,
    parameter int STALL_CNT_W = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    dual_issue_scheduler_if.slave bus
);
    typedef enum logic {PAIR, HALF} state_t;

    localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);

    state_t                 r_state;
    logic [2:0]             r_cnt [32];
    logic [STALL_CNT_W-1:0] r_stall;

    logic   w_haz_0;
    logic   w_haz_1;
    logic   w_raw;
    logic   w_waw;
    logic   w_pair_ok;
    logic   w_vbr;
    logic   w_sbr;
    logic   w_vmem;
    logic   w_smem;
    logic   w_ready;
    logic   w_stall;
    state_t w_nxt;
    logic   w_ld_en;
    logic [4:0] w_ld_rd;

    assign w_haz_0 =
        (bus.dec_rs1_0 != 5'd0 && r_cnt[bus.dec_rs1_0] != 3'd0) ||
        (bus.dec_rs2_0 != 5'd0 && r_cnt[bus.dec_rs2_0] != 3'd0);
    assign w_haz_1 =
        (bus.dec_rs1_1 != 5'd0 && r_cnt[bus.dec_rs1_1] != 3'd0) ||
        (bus.dec_rs2_1 != 5'd0 && r_cnt[bus.dec_rs2_1] != 3'd0);

    assign w_raw = bus.dec_rf_we_0 && bus.dec_rd_0 != 5'd0 &&
                   (bus.dec_rd_0 == bus.dec_rs1_1 ||
                    bus.dec_rd_0 == bus.dec_rs2_1);
    assign w_waw = bus.dec_rf_we_0 && bus.dec_rf_we_1 &&
                   bus.dec_rd_0 != 5'd0 &&
                   bus.dec_rd_0 == bus.dec_rd_1;

    assign w_pair_ok = bus.dec_valid_1 && !w_haz_1 && !w_raw && !w_waw &&
                       !(bus.dec_is_mem_0 && bus.dec_is_mem_1) &&
                       !(bus.dec_is_ctrl_0 && bus.dec_is_ctrl_1) &&
                       !bus.dec_is_ctrl_0;

    // Issue decision and steering for the current cycle.
    always_comb begin
        w_vbr   = 1'b0;
        w_sbr   = 1'b0;
        w_vmem  = 1'b0;
        w_smem  = 1'b0;
        w_ready = 1'b0;
        w_stall = 1'b0;
        w_nxt   = r_state;
        if (bus.flush) begin
            w_ready = 1'b1;
            w_nxt   = PAIR;
        end else if (r_state == HALF) begin
            if (!bus.dec_valid_1) begin
                w_ready = 1'b1;
                w_nxt   = PAIR;
            end else if (w_haz_1) begin
                w_stall = 1'b1;
            end else begin
                if (bus.dec_is_mem_1) begin
                    w_vmem = 1'b1;
                    w_smem = 1'b1;
                end else begin
                    w_vbr = 1'b1;
                    w_sbr = 1'b1;
                end
                w_ready = 1'b1;
                w_nxt   = PAIR;
            end
        end else if (bus.dec_valid_0) begin
            if (w_haz_0) begin
                w_stall = 1'b1;
            end else if (w_pair_ok) begin
                w_vbr   = 1'b1;
                w_vmem  = 1'b1;
                w_sbr   = bus.dec_is_mem_0;
                w_smem  = !bus.dec_is_mem_0;
                w_ready = 1'b1;
            end else begin
                if (bus.dec_is_mem_0) begin
                    w_vmem = 1'b1;
                end else begin
                    w_vbr = 1'b1;
                end
                w_ready = !bus.dec_valid_1;
                w_nxt   = bus.dec_valid_1 ? HALF : PAIR;
            end
        end else if (bus.dec_valid_1) begin
            if (w_haz_1) begin
                w_stall = 1'b1;
            end else begin
                if (bus.dec_is_mem_1) begin
                    w_vmem = 1'b1;
                    w_smem = 1'b1;
                end else begin
                    w_vbr = 1'b1;
                    w_sbr = 1'b1;
                end
                w_ready = 1'b1;
            end
        end else begin
            w_ready = 1'b1;
        end
    end

    // Only the Memory pipe can carry a load, so at most one per cycle.
    assign w_ld_en = w_vmem &&
                     (w_smem ? bus.dec_is_load_1 : bus.dec_is_load_0) &&
                     w_ld_rd != 5'd0;
    assign w_ld_rd = w_smem ? bus.dec_rd_1 : bus.dec_rd_0;

    assign bus.dec_ready     = rst_n & w_ready;
    assign bus.iss_valid_br  = rst_n & w_vbr;
    assign bus.iss_valid_mem = rst_n & w_vmem;
    assign bus.iss_src_br    = rst_n & w_sbr;
    assign bus.iss_src_mem   = rst_n & w_smem;
    assign bus.stall_cnt     = r_stall;

    // Issue FSM: PAIR holds both slots, HALF after slot 0 went alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PAIR;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Load-use scoreboard; a new load overrides the decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_ld_en && w_ld_rd == 5'(i)) begin
                    r_cnt[i] <= LD_INIT;
                end else if (r_cnt[i] != 3'd0) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
        end
    end

    // Saturating count of blocked-candidate cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_stall && r_stall != '1) begin
            r_stall <= r_stall + 1'b1;
        end
    end
endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Issue-stage controller for the two-wide in-order core. Each cycle it inspects the decoded instruction pair held in the decode/issue latch and decides which slot(s) issue and which execution pipe (Branch pipe or Memory pipe) each one goes to. It drives the select and valid controls of the issue steering mux and back-pressures decode. It also tracks load-use hazards with a per-register scoreboard. It holds no instruction payload; decode keeps the pair stable until `dec_ready`.

## Interface
- `LOAD_LAT`, 2, cycles from load issue until its result is forwardable; legal range 1..7
- `STALL_CNT_W`, 32, width of the stall performance counter

- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `dec_valid_0/1` in 1 each: slot holds a valid instruction (slot 0 is older)
- `dec_is_mem_0/1` in 1 each: load or store
- `dec_is_load_0/1` in 1 each: load (implies `is_mem`)
- `dec_is_ctrl_0/1` in 1 each: branch, JAL or JALR
- `dec_rs1_0/1`, `dec_rs2_0/1` in 5 each: source registers; x0 never causes a hazard
- `dec_rd_0/1` in 5 each: destination register
- `dec_rf_we_0/1` in 1 each: writes the register file
- `flush` in 1: branch-redirect kill of the pair currently in issue
- `dec_ready` out 1: pair fully consumed this cycle; decode may advance at the next edge
- `iss_valid_br`, `iss_valid_mem` out 1 each: Branch pipe / Memory pipe receives an instruction this cycle
- `iss_src_br`, `iss_src_mem` out 1 each: decode slot index feeding that pipe; 0 when the matching valid is 0
- `stall_cnt` out STALL_CNT_W: saturating count of cycles in which a valid instruction was pending but nothing issued

## Operation
- FSM has two states:
  - PAIR: both slots are pending.
  - HALF: slot 0 has issued and slot 1 is pending.
- Reset state is PAIR. All scoreboard counters and `stall_cnt` reset to 0.
- Scoreboard: one down-counter per register x1..x31, width 3.
  - An issued load with rd≠0 loads `cnt[rd] = LOAD_LAT-1`.
  - Nonzero counters decrement every cycle.
  - If a load and a decrement hit the same entry in the same cycle, the load wins.
  - An instruction has a scoreboard hazard when its rs1 or rs2 is nonzero with `cnt ≠ 0`.
- Candidate in PAIR: slot 0 if `dec_valid_0`, otherwise slot 1 evaluated alone. Candidate in HALF: slot 1.
- Single issue: a candidate with no scoreboard hazard issues.
- Pipe choice:
  - mem → Memory pipe
  - ctrl → Branch pipe
  - ALU → Branch pipe
- Dual issue in PAIR requires all of the following:
  - both slots valid and slot 0 issuing
  - slot 1 has no scoreboard hazard
  - no RAW: slot 0 `rf_we` with rd≠0 matching rs1_1 or rs2_1
  - no WAW: both write the same nonzero rd
  - not both mem
  - not both ctrl
  - slot 0 is not ctrl
- Dual-issue steering:
  - The mem op goes to the Memory pipe and the other slot goes to the Branch pipe.
  - If both are ALU: slot 0 → Branch pipe, slot 1 → Memory pipe.
- Transitions:
  - PAIR, dual issue, or a single valid slot issued → `dec_ready=1`, stay PAIR.
  - PAIR, only slot 0 issued with slot 1 valid → `dec_ready=0`, go to HALF.
  - HALF, slot 1 issued → `dec_ready=1`, go to PAIR.
  - Blocked candidate → no issue, `dec_ready=0`, state unchanged, `stall_cnt` increments.
  - Both slots invalid → `dec_ready=1`, no issue, no stall count.
- `flush` has top priority:
  - both `iss_valid_*` are 0 and `dec_ready=1`
  - next state is PAIR
  - scoreboard keeps counting, because older loads are still in flight
  - no stall count
- `stall_cnt` saturates at all-ones.

## Timing
- Issue decision and all outputs are combinational from the decode inputs, scoreboard and state, within the same cycle.
- State, scoreboard and `stall_cnt` update on the rising edge of `clk`.
- Load-use penalty is `LOAD_LAT-1` stall cycles. With `LOAD_LAT=1` there is never a scoreboard stall.
- While `rst_n=0`: `dec_ready=0`, `iss_valid_*=0`, `iss_src_*=0`, `stall_cnt=0`.
- Reset asserted mid-HALF discards the pending slot 1. The first post-reset cycle is PAIR.

## Test plan
- ALU `add x3` in slot 0, `lw x5` in slot 1, independent → same cycle: `iss_valid_br=1/src 0`, `iss_valid_mem=1/src 1`, `dec_ready=1`.
- `add x3` then `sub x4,x3,x1` → cycle 0: slot 0 to Branch pipe, `dec_ready=0`, go to HALF; cycle 1: slot 1 to Branch pipe, `dec_ready=1`, state PAIR.
- Two `sw` ops → split issue: both go to the Memory pipe on consecutive cycles. Also two branches → split issue: both go to the Branch pipe on consecutive cycles.
- `LOAD_LAT=3`: `lw x7` issues at t; a pair reading x7 is presented at t+1 → nothing issues at t+1 and t+2 (`stall_cnt` +2); it issues at t+3.
- Flush while in HALF → no issue, `dec_ready=1`, next state PAIR; a pending `cnt[x7]=2` still reaches 0 two cycles later.
- Force `stall_cnt` to all-ones, then stall → value holds. Assert `rst_n` low mid-stall → all outputs 0 immediately, without waiting for a clock edge.
